// File: rtl/wb_regbank.sv
// Writeback-side register bank: four architectural registers, two bypassed
// combinational read ports, and a per-register in-flight write scoreboard.
module wb_regbank #(
  parameter int unsigned NREG         = 4,
  parameter int unsigned DW           = 8,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [1:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [1:0]    rs1,
  input  logic          rs1_use,
  input  logic [1:0]    rs2,
  input  logic          rs2_use,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          issue_valid,
  input  logic [1:0]    issue_rd,
  output logic          stall,
  output logic          sb_err
);

  logic [DW-1:0] regs [NREG];
  logic [1:0]    cnt  [NREG];

  logic wb_hit1, wb_hit2, wb_hit_issue;
  logic src_haz1, src_haz2, cap_haz;
  logic issue_fire;

  always_comb begin
    wb_hit1      = wb_we && (wb_rd == rs1);
    wb_hit2      = wb_we && (wb_rd == rs2);
    wb_hit_issue = wb_we && (wb_rd == issue_rd);

    rdata1 = wb_hit1 ? wb_data : regs[rs1];
    rdata2 = wb_hit2 ? wb_data : regs[rs2];

    // A source is ready when its last pending write is being bypassed now.
    src_haz1 = rs1_use && (cnt[rs1] != 2'd0) && !((cnt[rs1] == 2'd1) && wb_hit1);
    src_haz2 = rs2_use && (cnt[rs2] != 2'd0) && !((cnt[rs2] == 2'd1) && wb_hit2);
    cap_haz  = (cnt[issue_rd] == 2'(MAX_INFLIGHT)) && !wb_hit_issue;

    stall      = issue_valid && (src_haz1 || src_haz2 || cap_haz);
    issue_fire = issue_valid && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_we) begin
        regs[wb_rd] <= wb_data;
        if (cnt[wb_rd] == 2'd0) sb_err <= 1'b1;
      end
      for (int unsigned i = 0; i < NREG; i++) begin
        // Simultaneous issue and retire on the same register cancel out.
        if ((issue_fire && (issue_rd == 2'(i))) &&
            !(wb_we && (wb_rd == 2'(i)) && (cnt[i] != 2'd0)))
          cnt[i] <= cnt[i] + 2'd1;
        else if (!(issue_fire && (issue_rd == 2'(i))) &&
                 (wb_we && (wb_rd == 2'(i)) && (cnt[i] != 2'd0)))
          cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

endmodule
